// File: rtl/sd_sector_streamer_pkg.sv
// Shared definitions for the SD sector streamer.
//   SECTOR_BYTES_DEFAULT : default bytes per sector
//   state_e              : control FSM state encoding
//   idx_width()          : width of a byte index within a sector
package sd_sector_streamer_pkg;

    localparam int unsigned SECTOR_BYTES_DEFAULT = 512;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StLoad   = 2'b01,
        StStream = 2'b11,
        StDone   = 2'b10
    } state_e;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sd_sector_streamer_if.sv
// Sector-in / byte-out bundle of the SD sector streamer.
//   FINISH, READ_DATA        : sector from the SD read data receiver
//   BYTE_OUT/VALID/READY/INDEX: byte stream handshake to the consumer
//   SECTOR_DONE, BUSY, OVERRUN: status
// Modports: slave = streamer, master = receiver/consumer side.
interface sd_sector_streamer_if #(
    parameter int unsigned SECTOR_BYTES = sd_sector_streamer_pkg::SECTOR_BYTES_DEFAULT
);
    localparam int unsigned IdxW = sd_sector_streamer_pkg::idx_width(SECTOR_BYTES);

    logic                      FINISH;
    logic [8*SECTOR_BYTES-1:0] READ_DATA;
    logic [7:0]                BYTE_OUT;
    logic                      BYTE_VALID;
    logic                      BYTE_READY;
    logic [IdxW-1:0]           BYTE_INDEX;
    logic                      SECTOR_DONE;
    logic                      BUSY;
    logic                      OVERRUN;

    modport slave (
        input  FINISH, READ_DATA, BYTE_READY,
        output BYTE_OUT, BYTE_VALID, BYTE_INDEX, SECTOR_DONE, BUSY, OVERRUN
    );

    modport master (
        output FINISH, READ_DATA, BYTE_READY,
        input  BYTE_OUT, BYTE_VALID, BYTE_INDEX, SECTOR_DONE, BUSY, OVERRUN
    );

endinterface

// File: rtl/sd_sector_buffer.sv
// Sector storage: whole-sector write, byte read by index.
//   clk_i     : clock
//   we_i      : write wr_data_i into bank wr_bank_i
//   wr_bank_i : bank to write (ignored with one bank)
//   wr_data_i : full sector, byte 0 in the top 8 bits
//   rd_bank_i : bank to read (ignored with one bank)
//   rd_idx_i  : byte offset to read
//   rd_byte_o : selected byte
module sd_sector_buffer
    import sd_sector_streamer_pkg::*;
#(
    parameter int unsigned SectorBytes = SECTOR_BYTES_DEFAULT,
    parameter int unsigned NumBanks    = 1,
    parameter int unsigned IdxW        = idx_width(SectorBytes)
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic                     wr_bank_i,
    input  logic [8*SectorBytes-1:0] wr_data_i,
    input  logic                     rd_bank_i,
    input  logic [IdxW-1:0]          rd_idx_i,
    output logic [7:0]               rd_byte_o
);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(SectorBytes - 1);

    // Byte 0 is the most significant byte, so index i lives at packed slot LastIdx - i.
    logic [SectorBytes-1:0][7:0] rd_sector;

    if (NumBanks > 1) begin : g_dual
        logic [1:0][8*SectorBytes-1:0] mem_q;

        always_ff @(posedge clk_i) begin
            if (we_i) begin
                mem_q[wr_bank_i] <= wr_data_i;
            end
        end

        assign rd_sector = mem_q[rd_bank_i];
    end else begin : g_single
        logic [8*SectorBytes-1:0] mem_q;
        logic                     unused_bank;

        assign unused_bank = wr_bank_i ^ rd_bank_i;

        always_ff @(posedge clk_i) begin
            if (we_i) begin
                mem_q <= wr_data_i;
            end
        end

        assign rd_sector = mem_q;
    end

    assign rd_byte_o = rd_sector[LastIdx - rd_idx_i];

endmodule

// File: rtl/sd_sector_streamer.sv
// Streams a captured SD sector out one byte at a time over a valid/ready handshake.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : sd_sector_streamer_if.slave (sector in, byte stream out, status)
// Build option: define SD_SECTOR_DOUBLE_BUFFER_EN to add a second sector buffer so a
// sector arriving during streaming is held and streamed right after the current one.
module sd_sector_streamer
    import sd_sector_streamer_pkg::*;
#(
    parameter int unsigned SECTOR_BYTES = SECTOR_BYTES_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    sd_sector_streamer_if.slave  bus
);
`ifdef SD_SECTOR_DOUBLE_BUFFER_EN
    localparam int unsigned NumBanks = 2;
`else
    localparam int unsigned NumBanks = 1;
`endif
    localparam bit              DoubleBuf = (NumBanks > 1);
    localparam int unsigned     IdxW      = idx_width(SECTOR_BYTES);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(SECTOR_BYTES - 1);

    state_e          state_q;
    logic            finish_q;
    logic [IdxW-1:0] idx_q;
    logic            valid_q;
    logic            done_q;
    logic            pend_q;     // second bank holds a sector waiting to stream
    logic            bank_q;     // bank currently being streamed
    logic            overrun_q;

    logic rise;
    logic take_idle;
    logic take_pend;
    logic drop;
    logic wr_bank;
    logic [7:0] rd_byte;

    assign rise      = bus.FINISH & ~finish_q;
    assign take_idle = rise & (state_q == StIdle);
    assign take_pend = DoubleBuf & rise & (state_q != StIdle) & ~pend_q;
    assign drop      = rise & ~take_idle & ~take_pend;
    // From idle the sector goes into the bank about to be streamed, otherwise the spare one.
    assign wr_bank   = take_idle ? bank_q : ~bank_q;

    sd_sector_buffer #(
        .SectorBytes (SECTOR_BYTES),
        .NumBanks    (NumBanks),
        .IdxW        (IdxW)
    ) u_buffer (
        .clk_i     (CLK),
        .we_i      (take_idle | take_pend),
        .wr_bank_i (wr_bank),
        .wr_data_i (bus.READ_DATA),
        .rd_bank_i (bank_q),
        .rd_idx_i  (idx_q),
        .rd_byte_o (rd_byte)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            finish_q  <= 1'b0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            pend_q    <= 1'b0;
            bank_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            finish_q <= bus.FINISH;
            done_q   <= 1'b0;
            if (drop) begin
                overrun_q <= 1'b1;
            end
            if (take_pend) begin
                pend_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (take_idle) begin
                        state_q <= StLoad;
                        idx_q   <= '0;
                    end
                end
                StLoad: begin
                    state_q <= StStream;
                    valid_q <= 1'b1;
                end
                StStream: begin
                    if (bus.BYTE_READY) begin
                        if (idx_q == LastIdx) begin
                            state_q <= StDone;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    // A sector captured in this very cycle counts as pending too.
                    if (pend_q || take_pend) begin
                        state_q <= StLoad;
                        idx_q   <= '0;
                        bank_q  <= ~bank_q;
                        pend_q  <= 1'b0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.BYTE_VALID  = valid_q;
    assign bus.BYTE_OUT    = valid_q ? rd_byte : 8'h00;
    assign bus.BYTE_INDEX  = idx_q;
    assign bus.SECTOR_DONE = done_q;
    assign bus.BUSY        = (state_q != StIdle) | pend_q;
    assign bus.OVERRUN     = overrun_q;

endmodule

// File: tb/tb_sd_sector_streamer.sv
// Self-checking bench for sd_sector_streamer: a queue-based reference model predicts the
// outputs every cycle; directed scenarios add literal expectations.
// Honours SD_SECTOR_DOUBLE_BUFFER_EN to pick the expected buffer capacity.
module tb_sd_sector_streamer;
    import sd_sector_streamer_pkg::*;

    localparam int unsigned SB = SECTOR_BYTES_DEFAULT;
    localparam int unsigned SW = 8 * SB;
`ifdef SD_SECTOR_DOUBLE_BUFFER_EN
    localparam int Cap = 2;
`else
    localparam int Cap = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sd_sector_streamer_if #(.SECTOR_BYTES(SB)) bus ();

    sd_sector_streamer #(.SECTOR_BYTES(SB)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sbyte(input logic [SW-1:0] sec, input int i);
        logic [SW-1:0] t;
        t = sec >> (8 * (SB - 1 - i));
        return t[7:0];
    endfunction

    function automatic logic [SW-1:0] pattern_sector();
        logic [SW-1:0] s;
        s = '0;
        for (int i = 0; i < SB; i++) s = (s << 8) | SW'(i % 256);
        return s;
    endfunction

    function automatic logic [SW-1:0] rand_sector();
        logic [SW-1:0] s;
        s = '0;
        for (int i = 0; i < SW / 32; i++) s = (s << 32) | SW'($urandom());
        return s;
    endfunction

    // ---------------- reference model ----------------
    logic [SW-1:0] mq[$];          // sectors held, front = the one being streamed
    logic m_fin_prev = 1'b0;
    logic exp_valid = 1'b0, exp_load = 1'b0, exp_done = 1'b0;
    logic exp_busy = 1'b0, exp_ovr = 1'b0;
    int   exp_idx = 0;
    logic [7:0] exp_byte = 8'h00;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_fin_prev = 1'b0;
                exp_valid = 1'b0; exp_load = 1'b0; exp_done = 1'b0;
                exp_busy = 1'b0; exp_ovr = 1'b0; exp_idx = 0; exp_byte = 8'h00;
            end else begin : step
                logic rise, n_valid, n_load, n_done;
                int n_idx;
                rise = bus.FINISH && !m_fin_prev;
                m_fin_prev = bus.FINISH;
                if (rise) begin
                    if (mq.size() < Cap) mq.push_back(bus.READ_DATA);
                    else exp_ovr = 1'b1;
                end
                n_valid = 1'b0; n_load = 1'b0; n_done = 1'b0; n_idx = exp_idx;
                if (exp_load) begin
                    n_valid = 1'b1;
                    n_idx = 0;
                end else if (exp_valid) begin
                    if (bus.BYTE_READY && exp_idx == SB - 1) n_done = 1'b1;
                    else begin
                        n_valid = 1'b1;
                        if (bus.BYTE_READY) n_idx = exp_idx + 1;
                    end
                end else if (exp_done) begin
                    mq.delete(0);
                    if (mq.size() > 0) n_load = 1'b1;
                end else if (mq.size() > 0) begin
                    n_load = 1'b1;
                end
                exp_valid = n_valid; exp_load = n_load; exp_done = n_done; exp_idx = n_idx;
                exp_busy = (mq.size() > 0);
                exp_byte = n_valid ? sbyte(mq[0], n_idx) : 8'h00;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("valid", 32'(bus.BYTE_VALID), 32'(exp_valid));
            check("sector_done", 32'(bus.SECTOR_DONE), 32'(exp_done));
            check("busy", 32'(bus.BUSY), 32'(exp_busy));
            check("overrun", 32'(bus.OVERRUN), 32'(exp_ovr));
            if (exp_valid) begin
                check("index", 32'(bus.BYTE_INDEX), 32'(exp_idx));
                check("byte", 32'(bus.BYTE_OUT), 32'(exp_byte));
            end else begin
                check("byte_idle", 32'(bus.BYTE_OUT), 32'h0);
            end
        end
    end

    // Record what the DUT actually delivered.
    logic [7:0] dut_stream[$];
    int dut_done = 0;
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && bus.BYTE_VALID && bus.BYTE_READY) dut_stream.push_back(bus.BYTE_OUT);
            if (rst_n && bus.SECTOR_DONE) dut_done++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (entered at a negedge) ----------------
    task automatic pulse_finish(input logic [SW-1:0] sec);
        bus.READ_DATA = sec;
        bus.FINISH = 1'b1;
        @(negedge clk);
        bus.FINISH = 1'b0;
    endtask

    task automatic run_until_idle(input int mode, input string name);
        int cyc;
        cyc = 0;
        while (bus.BUSY && cyc < 5000) begin
            case (mode)
                0: bus.BYTE_READY = 1'b1;
                1: bus.BYTE_READY = ~bus.BYTE_READY;
                default: bus.BYTE_READY = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            cyc++;
        end
        check({name, "_idle"}, 32'(bus.BUSY), 32'h0);
    endtask

    task automatic wait_index(input int n, input string name);
        int cyc;
        cyc = 0;
        while (!(bus.BYTE_VALID && bus.BYTE_INDEX == n) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_reach_index"}, 32'(bus.BYTE_INDEX), 32'(n));
    endtask

    task automatic check_zero(input string name);
        check({name, "_valid"}, 32'(bus.BYTE_VALID), 32'h0);
        check({name, "_byte"}, 32'(bus.BYTE_OUT), 32'h0);
        check({name, "_index"}, 32'(bus.BYTE_INDEX), 32'h0);
        check({name, "_done"}, 32'(bus.SECTOR_DONE), 32'h0);
        check({name, "_busy"}, 32'(bus.BUSY), 32'h0);
        check({name, "_overrun"}, 32'(bus.OVERRUN), 32'h0);
    endtask

    task automatic check_stream(input int base, input logic [7:0] expq[$], input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < expq.size(); i++) begin
            if (base + i >= dut_stream.size() || dut_stream[base + i] !== expq[i]) bad++;
        end
        check({name, "_count"}, 32'(dut_stream.size() - base), 32'(expq.size()));
        check({name, "_content_errors"}, 32'(bad), 32'h0);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [SW-1:0] secs[3];
        logic [7:0] expq[$];
        int base, dbase;

        bus.FINISH = 1'b0;
        bus.READ_DATA = '0;
        bus.BYTE_READY = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Counting pattern, always ready: latency, order, single done pulse.
        base = dut_stream.size(); dbase = dut_done;
        bus.BYTE_READY = 1'b1;
        pulse_finish(pattern_sector());
        check("t1_load_cycle_valid", 32'(bus.BYTE_VALID), 32'h0);
        check("t1_busy", 32'(bus.BUSY), 32'h1);
        @(negedge clk);
        check("t1_first_valid", 32'(bus.BYTE_VALID), 32'h1);
        check("t1_first_byte", 32'(bus.BYTE_OUT), 32'h00);
        check("t1_first_index", 32'(bus.BYTE_INDEX), 32'h0);
        run_until_idle(0, "t1");
        check("t1_bytes", 32'(dut_stream.size() - base), 32'd512);
        check("t1_done_pulses", 32'(dut_done - dbase), 32'd1);
        check("t1_byte300", 32'(dut_stream[base + 300]), 32'h2C);
        check("t1_byte256", 32'(dut_stream[base + 256]), 32'h00);
        check("t1_byte511", 32'(dut_stream[base + 511]), 32'hFF);

        // Ready toggling every cycle.
        base = dut_stream.size(); dbase = dut_done;
        secs[0] = rand_sector();
        pulse_finish(secs[0]);
        run_until_idle(1, "t2");
        expq.delete();
        for (int i = 0; i < SB; i++) expq.push_back(sbyte(secs[0], i));
        check_stream(base, expq, "t2");
        check("t2_done_pulses", 32'(dut_done - dbase), 32'd1);

        // FINISH held high for five cycles is one sector.
        base = dut_stream.size(); dbase = dut_done;
        bus.BYTE_READY = 1'b1;
        bus.READ_DATA = rand_sector();
        bus.FINISH = 1'b1;
        repeat (5) @(negedge clk);
        bus.FINISH = 1'b0;
        run_until_idle(0, "t3");
        check("t3_bytes", 32'(dut_stream.size() - base), 32'd512);
        check("t3_done_pulses", 32'(dut_done - dbase), 32'd1);

        // Second sector arriving at index 100.
        base = dut_stream.size(); dbase = dut_done;
        secs[0] = rand_sector();
        secs[1] = rand_sector();
        pulse_finish(secs[0]);
        wait_index(100, "t4");
        pulse_finish(secs[1]);
        run_until_idle(0, "t4");
        expq.delete();
        for (int s = 0; s < Cap; s++)
            for (int i = 0; i < SB; i++) expq.push_back(sbyte(secs[s], i));
        check_stream(base, expq, "t4");
        check("t4_done_pulses", 32'(dut_done - dbase), 32'(Cap));
        check("t4_overrun", 32'(bus.OVERRUN), 32'(Cap == 1));

        // Reset in the middle of a sector.
        pulse_finish(rand_sector());
        wait_index(300, "t5");
        #2 rst_n = 1'b0;
        #1 check_zero("t5_rst");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        base = dut_stream.size();
        repeat (20) @(negedge clk);
        check("t5_quiet_bytes", 32'(dut_stream.size() - base), 32'h0);
        check("t5_quiet_valid", 32'(bus.BYTE_VALID), 32'h0);
        secs[0] = rand_sector();
        pulse_finish(secs[0]);
        run_until_idle(0, "t5");
        expq.delete();
        for (int i = 0; i < SB; i++) expq.push_back(sbyte(secs[0], i));
        check_stream(base, expq, "t5");

        // Third sector while every buffer is occupied.
        base = dut_stream.size();
        for (int s = 0; s < 3; s++) secs[s] = rand_sector();
        pulse_finish(secs[0]);
        wait_index(50, "t6a");
        pulse_finish(secs[1]);
        wait_index(60, "t6b");
        pulse_finish(secs[2]);
        run_until_idle(0, "t6");
        expq.delete();
        for (int s = 0; s < Cap; s++)
            for (int i = 0; i < SB; i++) expq.push_back(sbyte(secs[s], i));
        check_stream(base, expq, "t6");
        check("t6_overrun", 32'(bus.OVERRUN), 32'h1);

        // Random ready and random sector arrivals, checked by the model.
        for (int c = 0; c < 4000; c++) begin
            bus.BYTE_READY = ($urandom_range(0, 3) != 0);
            if (!bus.FINISH && $urandom_range(0, 399) == 0) begin
                bus.READ_DATA = rand_sector();
                bus.FINISH = 1'b1;
            end else if (bus.FINISH && $urandom_range(0, 2) != 0) begin
                bus.FINISH = 1'b0;
            end
            @(negedge clk);
        end
        bus.FINISH = 1'b0;
        run_until_idle(2, "t7");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sd_sector_streamer.md
SD_SECTOR_STREAMER -- requirements
Module: sd_sector_streamer

Interface
REQ-001 SHALL have parameter SECTOR_BYTES, default 512, meaning bytes per sector; the sector bus is 8*SECTOR_BYTES bits wide.
REQ-002 SHALL have port CLK  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port FINISH  input  1  sector-complete flag from the SD read data receiver; its rising edge marks READ_DATA valid.
REQ-005 SHALL have port READ_DATA  input  8*SECTOR_BYTES  captured sector; bits [top:top-7] hold byte 0, the first byte received.
REQ-006 SHALL have port BYTE_OUT  output  8  current byte.
REQ-007 SHALL have port BYTE_VALID  output  1  BYTE_OUT and BYTE_INDEX are valid.
REQ-008 SHALL have port BYTE_READY  input  1  consumer accepts the byte.
REQ-009 SHALL have port BYTE_INDEX  output  clog2(SECTOR_BYTES)  byte offset within the sector.
REQ-010 SHALL have port SECTOR_DONE  output  1  one-cycle pulse after the last byte is accepted.
REQ-011 SHALL have port BUSY  output  1  high while any sector is held or being streamed.
REQ-012 SHALL have port OVERRUN  output  1  sticky flag: a sector arrived with no free buffer.

Function
REQ-013 SHALL detect the FINISH rising edge with a registered copy of FINISH; a level held high SHALL count as one sector.
REQ-014 SHALL, on a detected edge with a free buffer, copy READ_DATA into that buffer in the same cycle.
REQ-015 SHALL implement states IDLE, LOAD, STREAM, DONE.
REQ-016 SHALL go IDLE->LOAD on an edge; LOAD->STREAM after one cycle; STREAM->DONE when byte SECTOR_BYTES-1 is accepted; DONE->LOAD if a sector is pending, else DONE->IDLE.
REQ-017 SHALL assert BYTE_VALID only in STREAM; first BYTE_VALID occurs 2 cycles after the FINISH edge.
REQ-018 SHALL count a byte as transferred on a cycle with BYTE_VALID and BYTE_READY both high; BYTE_INDEX then increments by 1.
REQ-019 SHALL hold BYTE_OUT and BYTE_INDEX stable while BYTE_VALID is high and BYTE_READY is low.
REQ-020 SHALL sustain one byte per cycle while BYTE_READY stays high: 512 bytes in 512 consecutive cycles.
REQ-021 SHALL pulse SECTOR_DONE for exactly one cycle, in the DONE state.
REQ-022 SHALL reset BYTE_INDEX to 0 on entry to LOAD; the index never wraps inside a sector.
REQ-023 SHALL, on an edge with no free buffer, drop the incoming sector, keep the current stream intact and set OVERRUN; OVERRUN clears only on reset.
REQ-024 SHALL drive BUSY as (state != IDLE) OR pending buffer full.

Reset
REQ-025 SHALL, while RST_N is low, asynchronously force state IDLE, BYTE_VALID 0, BYTE_OUT 0, BYTE_INDEX 0, SECTOR_DONE 0, BUSY 0, OVERRUN 0, buffers empty and the FINISH edge register 0.
REQ-026 SHALL discard any partially streamed sector when reset is asserted mid-stream; after release, output resumes only after a new FINISH edge.

Configuration
REQ-027 SHALL, with SD_SECTOR_DOUBLE_BUFFER_EN defined, provide a second sector buffer: an edge during STREAM fills it and streaming resumes from it via DONE->LOAD.
REQ-028 SHALL, without SD_SECTOR_DOUBLE_BUFFER_EN, provide one buffer only: any edge outside IDLE is an overrun under REQ-023.

Structure
REQ-029 SHALL take the state encodings (IDLE=2'b00, LOAD=2'b01, STREAM=2'b11, DONE=2'b10) and the default SECTOR_BYTES from the shared header package.
REQ-030 SHALL place the buffer plus byte-select multiplexer in one sub-module, sd_sector_buffer (write-whole, read-by-index); the control FSM stays in the top.

Verification
REQ-031 SHALL verify: READ_DATA = bytes 0x00..0xFF repeated, FINISH pulse, BYTE_READY=1 -> bytes 0x00,0x01,...,0xFF,0x00,... on indices 0..511, then one SECTOR_DONE pulse.
REQ-032 SHALL verify: BYTE_READY toggled 1/0 every cycle -> 512 bytes delivered in order; BYTE_OUT stable on every stalled cycle.
REQ-033 SHALL verify: FINISH held high 5 cycles -> exactly one sector streamed.
REQ-034 SHALL verify: second FINISH at index 100 -> with macro, 1024 bytes from two distinct sectors back-to-back and OVERRUN=0; without macro, 512 bytes and OVERRUN=1.
REQ-035 SHALL verify: RST_N low at index 300 -> all outputs 0 within the same cycle; no BYTE_VALID until the next FINISH edge.
REQ-036 SHALL verify: third FINISH while both buffers are full (macro defined) -> OVERRUN=1; first two sectors intact.
